// File: rtl/shared_mem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// shared_mem_arbiter_pkg
// Types and constants shared by the two-requester memory arbiter.
//   req_id_t  : requester identifier (1 bit), REQ0 / REQ1
//   req_t     : one request record {we, addr, wdata} at the default widths
//   ADDR_W / DATA_W / CNT_W : default widths used by the top-level parameters
//   id_to_onehot : converts a requester id into a one-hot grant vector
// -----------------------------------------------------------------------------
package shared_mem_arbiter_pkg;

    localparam int ADDR_W = 2;
    localparam int DATA_W = 4;
    localparam int CNT_W  = 8;

    typedef logic req_id_t;

    localparam req_id_t REQ0 = 1'b0;
    localparam req_id_t REQ1 = 1'b1;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    // One-hot grant vector for a given requester id.
    function automatic logic [1:0] id_to_onehot(input req_id_t id);
        logic [1:0] oh;
        if (id == REQ1) begin
            oh = 2'b10;
        end else begin
            oh = 2'b01;
        end
        return oh;
    endfunction

endpackage

// File: rtl/shared_mem_arbiter_rr_arbiter2.sv
// -----------------------------------------------------------------------------
// rr_arbiter2
// Two-way round-robin grant logic with the last-grant register.
// Ports:
//   clock  : clock
//   clear  : synchronous active-high reset; forces gnt to zero while high
//   valid  : per-requester request valid
//   accept : a transfer was accepted this cycle (updates last_gnt)
//   gnt    : one-hot (or zero) combinational grant
// -----------------------------------------------------------------------------
module rr_arbiter2
    import shared_mem_arbiter_pkg::*;
(
    input  logic       clock,
    input  logic       clear,
    input  logic [1:0] valid,
    input  logic       accept,
    output logic [1:0] gnt
);

    req_id_t    last_gnt_r;
    logic [1:0] gnt_s;

    // Grant decision: a lone requester wins outright, a tie goes to the
    // requester that was not served most recently.
    always_comb begin
        gnt_s = 2'b00;
        if (clear) begin
            gnt_s = 2'b00;
        end else begin
            case (valid)
                2'b01:   gnt_s = 2'b01;
                2'b10:   gnt_s = 2'b10;
                2'b11:   gnt_s = id_to_onehot(~last_gnt_r);
                default: gnt_s = 2'b00;
            endcase
        end
    end

    assign gnt = gnt_s;

    // Remember who was served last; idle cycles leave the history untouched
    // so fairness survives gaps in traffic.
    always_ff @(posedge clock) begin
        if (clear) begin
            last_gnt_r <= REQ1;
        end else if (accept) begin
            last_gnt_r <= gnt_s[1] ? REQ1 : REQ0;
        end else begin
            last_gnt_r <= last_gnt_r;
        end
    end

endmodule

// File: rtl/shared_mem_arbiter.sv
// -----------------------------------------------------------------------------
// shared_mem_arbiter
// Shares one single-port synchronous-read memory between two requesters with
// round-robin arbitration, zero-latency ready and one-cycle read responses.
// Ports:
//   clock, clear              : clock and synchronous active-high reset
//   req_valid/req_ready       : per-requester request handshake (bit i = req i)
//   req_we                    : per-requester write enable
//   req_addr0/1, req_wdata0/1 : per-requester address and write data
//   rsp_valid, rsp_data       : read response (rsp_data shared, qualified)
//   mem_en/we/addr/wdata      : memory port driven from the winning requester
//   mem_rdata                 : memory read data, valid the cycle after a read
//   conflict_cnt              : saturating count of cycles with both valid
// -----------------------------------------------------------------------------
module shared_mem_arbiter
    import shared_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = shared_mem_arbiter_pkg::ADDR_W,
    parameter int DATA_W = shared_mem_arbiter_pkg::DATA_W,
    parameter int CNT_W  = shared_mem_arbiter_pkg::CNT_W
) (
    input  logic              clock,
    input  logic              clear,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [1:0]        req_we,
    input  logic [ADDR_W-1:0] req_addr0,
    input  logic [ADDR_W-1:0] req_addr1,
    input  logic [DATA_W-1:0] req_wdata0,
    input  logic [DATA_W-1:0] req_wdata1,
    output logic [1:0]        rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [CNT_W-1:0]  conflict_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]        gnt_s;
    logic              accept_s;
    logic              mem_we_s;
    logic [ADDR_W-1:0] mem_addr_s;
    logic [DATA_W-1:0] mem_wdata_s;
    logic [1:0]        rsp_pend_r;
    logic [CNT_W-1:0]  conflict_cnt_r;

    assign accept_s = |(req_valid & gnt_s);

    rr_arbiter2 u_arb (
        .clock  (clock),
        .clear  (clear),
        .valid  (req_valid),
        .accept (accept_s),
        .gnt    (gnt_s)
    );

    // Memory port mux: the granted requester drives the port, idle is all zero.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_addr_s  = {ADDR_W{1'b0}};
        mem_wdata_s = {DATA_W{1'b0}};
        case (gnt_s)
            2'b01: begin
                mem_we_s    = req_we[REQ0];
                mem_addr_s  = req_addr0;
                mem_wdata_s = req_wdata0;
            end
            2'b10: begin
                mem_we_s    = req_we[REQ1];
                mem_addr_s  = req_addr1;
                mem_wdata_s = req_wdata1;
            end
            default: begin
                mem_we_s    = 1'b0;
                mem_addr_s  = {ADDR_W{1'b0}};
                mem_wdata_s = {DATA_W{1'b0}};
            end
        endcase
    end

    // Track which requester has a read in flight; a response lasts one cycle.
    always_ff @(posedge clock) begin
        if (clear) begin
            rsp_pend_r <= 2'b00;
        end else begin
            rsp_pend_r <= gnt_s & req_valid & ~req_we;
        end
    end

    // Count contention cycles, sticking at the maximum.
    always_ff @(posedge clock) begin
        if (clear) begin
            conflict_cnt_r <= {CNT_W{1'b0}};
        end else if ((req_valid == 2'b11) && (conflict_cnt_r != CNT_MAX)) begin
            conflict_cnt_r <= conflict_cnt_r + CNT_ONE;
        end else begin
            conflict_cnt_r <= conflict_cnt_r;
        end
    end

    assign req_ready    = gnt_s;
    assign mem_en       = |gnt_s;
    assign mem_we       = mem_we_s;
    assign mem_addr     = mem_addr_s;
    assign mem_wdata    = mem_wdata_s;
    // A response due in a cleared cycle is dropped, not delivered late.
    assign rsp_valid    = clear ? 2'b00 : rsp_pend_r;
    assign rsp_data     = mem_rdata;
    assign conflict_cnt = conflict_cnt_r;

endmodule

// File: tb/tb_shared_mem_arbiter.sv
module tb_shared_mem_arbiter;

    localparam int AW = 2;
    localparam int DW = 4;
    localparam int CW = 3;
    localparam int CMAX = 7;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic          clear = 1'b1;
    logic [1:0]    req_valid = 2'b00;
    logic [1:0]    req_ready;
    logic [1:0]    req_we = 2'b00;
    logic [AW-1:0] req_addr0 = '0;
    logic [AW-1:0] req_addr1 = '0;
    logic [DW-1:0] req_wdata0 = '0;
    logic [DW-1:0] req_wdata1 = '0;
    logic [1:0]    rsp_valid;
    logic [DW-1:0] rsp_data;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic [CW-1:0] conflict_cnt;

    shared_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
        .clock        (clock),
        .clear        (clear),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_addr0    (req_addr0),
        .req_addr1    (req_addr1),
        .req_wdata0   (req_wdata0),
        .req_wdata1   (req_wdata1),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .mem_en       (mem_en),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .conflict_cnt (conflict_cnt)
    );

    // Behavioural single-port synchronous-read memory attached to the DUT.
    logic [DW-1:0] mem [4] = '{4'd1, 4'd4, 4'd7, 4'd10};
    always @(posedge clock) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr];
        end
    end

    // Reference model state (what the block should hold, in plain terms).
    int            last_m = 1;
    logic [1:0]    pend_m = 2'b00;
    logic [DW-1:0] pdata_m = '0;
    int            cnt_m = 0;
    bit            known_m = 1'b0;
    logic [DW-1:0] sh [4] = '{4'd1, 4'd4, 4'd7, 4'd10};

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, compare every output with the model,
    // then advance the model across the coming edge.
    task automatic do_cycle(input logic clr, input logic [1:0] v, input logic [1:0] we,
                            input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                            input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                            output logic [1:0] er);
        int            g;
        logic          ewe;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        @(posedge clock);
        #1;
        clear = clr; req_valid = v; req_we = we;
        req_addr0 = a0; req_addr1 = a1; req_wdata0 = d0; req_wdata1 = d1;
        #4;
        g = -1;
        if (!clr) begin
            if (v == 2'b01)      g = 0;
            else if (v == 2'b10) g = 1;
            else if (v == 2'b11) g = 1 - last_m;
        end
        er  = (g < 0) ? 2'b00 : ((g == 0) ? 2'b01 : 2'b10);
        ewe = (g == 0) ? we[0] : ((g == 1) ? we[1] : 1'b0);
        ea  = (g == 0) ? a0 : ((g == 1) ? a1 : '0);
        ed  = (g == 0) ? d0 : ((g == 1) ? d1 : '0);
        chk("req_ready", 32'(req_ready), 32'(er));
        chk("mem_en", 32'(mem_en), 32'(g >= 0));
        chk("mem_we", 32'(mem_we), 32'(ewe));
        chk("mem_addr", 32'(mem_addr), 32'(ea));
        chk("mem_wdata", 32'(mem_wdata), 32'(ed));
        chk("rsp_valid", 32'(rsp_valid), clr ? 32'd0 : 32'(pend_m));
        if (!clr && pend_m != 2'b00) chk("rsp_data", 32'(rsp_data), 32'(pdata_m));
        if (known_m) chk("conflict_cnt", 32'(conflict_cnt), 32'(cnt_m));
        if (clr) begin
            last_m = 1; pend_m = 2'b00; cnt_m = 0; known_m = 1'b1;
        end else begin
            pend_m = 2'b00;
            if (g >= 0) begin
                last_m = g;
                if (ewe) sh[ea] = ed;
                else begin pend_m = er; pdata_m = sh[ea]; end
            end
            if (v == 2'b11 && cnt_m < CMAX) cnt_m++;
        end
    endtask

    initial begin
        logic [1:0]    er;
        bit            p0, p1;
        logic          w0, w1, clr;
        logic [AW-1:0] a0, a1;
        logic [DW-1:0] d0, d1;

        // Reset held two cycles with both requesting.
        do_cycle(1'b1, 2'b11, 2'b00, 2'd1, 2'd3, 4'd0, 4'd0, er);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_mem_en", 32'(mem_en), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        do_cycle(1'b1, 2'b11, 2'b00, 2'd1, 2'd3, 4'd0, 4'd0, er);
        chk("rst_cnt", 32'(conflict_cnt), 32'd0);

        // Contention: both read, grants alternate starting with requester 0.
        do_cycle(1'b0, 2'b11, 2'b00, 2'd1, 2'd3, 4'd0, 4'd0, er);
        chk("cont_g0", 32'(req_ready), 32'h1);
        chk("cont_r0", 32'(rsp_valid), 32'h0);
        do_cycle(1'b0, 2'b11, 2'b00, 2'd1, 2'd3, 4'd0, 4'd0, er);
        chk("cont_g1", 32'(req_ready), 32'h2);
        chk("cont_r1", 32'(rsp_valid), 32'h1);
        chk("cont_d1", 32'(rsp_data), 32'h4);
        do_cycle(1'b0, 2'b11, 2'b00, 2'd1, 2'd3, 4'd0, 4'd0, er);
        chk("cont_g2", 32'(req_ready), 32'h1);
        chk("cont_r2", 32'(rsp_valid), 32'h2);
        chk("cont_d2", 32'(rsp_data), 32'hA);
        do_cycle(1'b0, 2'b11, 2'b00, 2'd1, 2'd3, 4'd0, 4'd0, er);
        chk("cont_g3", 32'(req_ready), 32'h2);
        chk("cont_r3", 32'(rsp_valid), 32'h1);
        do_cycle(1'b0, 2'b00, 2'b00, 2'd0, 2'd0, 4'd0, 4'd0, er);
        chk("cont_r4", 32'(rsp_valid), 32'h2);
        chk("cont_cnt", 32'(conflict_cnt), 32'd4);

        // Single requester: req1 writes A to addr 2 then reads it back.
        do_cycle(1'b0, 2'b10, 2'b10, 2'd0, 2'd2, 4'd0, 4'hA, er);
        chk("wr_ready", 32'(req_ready), 32'h2);
        chk("wr_we", 32'(mem_we), 32'd1);
        chk("wr_addr", 32'(mem_addr), 32'd2);
        chk("wr_data", 32'(mem_wdata), 32'hA);
        do_cycle(1'b0, 2'b10, 2'b00, 2'd0, 2'd2, 4'd0, 4'd0, er);
        chk("rd_we", 32'(mem_we), 32'd0);
        do_cycle(1'b0, 2'b00, 2'b00, 2'd0, 2'd0, 4'd0, 4'd0, er);
        chk("rd_rsp_valid", 32'(rsp_valid), 32'h2);
        chk("rd_rsp_data", 32'(rsp_data), 32'hA);

        // Fairness across idle: req0 alone, idle gap, then a tie goes to 1.
        for (int i = 0; i < 3; i++) begin
            do_cycle(1'b0, 2'b01, 2'b00, 2'd0, 2'd0, 4'd0, 4'd0, er);
            chk("fair_solo", 32'(req_ready), 32'h1);
        end
        do_cycle(1'b0, 2'b00, 2'b00, 2'd0, 2'd0, 4'd0, 4'd0, er);
        do_cycle(1'b0, 2'b00, 2'b00, 2'd0, 2'd0, 4'd0, 4'd0, er);
        do_cycle(1'b0, 2'b11, 2'b00, 2'd0, 2'd1, 4'd0, 4'd0, er);
        chk("fair_tie", 32'(req_ready), 32'h2);

        // Saturation of the 3-bit counter.
        do_cycle(1'b1, 2'b00, 2'b00, 2'd0, 2'd0, 4'd0, 4'd0, er);
        for (int i = 0; i < 10; i++) do_cycle(1'b0, 2'b11, 2'b00, 2'd0, 2'd1, 4'd0, 4'd0, er);
        do_cycle(1'b0, 2'b00, 2'b00, 2'd0, 2'd0, 4'd0, 4'd0, er);
        chk("sat_cnt", 32'(conflict_cnt), 32'd7);

        // Reset right after an accepted read drops the response.
        do_cycle(1'b0, 2'b01, 2'b00, 2'd3, 2'd0, 4'd0, 4'd0, er);
        chk("mid_acc", 32'(req_ready), 32'h1);
        do_cycle(1'b1, 2'b00, 2'b00, 2'd0, 2'd0, 4'd0, 4'd0, er);
        chk("mid_rsp1", 32'(rsp_valid), 32'h0);
        do_cycle(1'b0, 2'b00, 2'b00, 2'd0, 2'd0, 4'd0, 4'd0, er);
        chk("mid_rsp2", 32'(rsp_valid), 32'h0);
        do_cycle(1'b0, 2'b11, 2'b00, 2'd0, 2'd0, 4'd0, 4'd0, er);
        chk("mid_last", 32'(req_ready), 32'h1);

        // Random traffic: each requester holds its request until granted.
        p0 = 1'b0; p1 = 1'b0;
        w0 = 1'b0; w1 = 1'b0; a0 = '0; a1 = '0; d0 = '0; d1 = '0;
        for (int n = 0; n < 3000; n++) begin
            if (!p0 && $urandom_range(0, 3) != 0) begin
                p0 = 1'b1; w0 = 1'($urandom_range(0, 1));
                a0 = AW'($urandom_range(0, 3)); d0 = DW'($urandom_range(0, 15));
            end
            if (!p1 && $urandom_range(0, 3) != 0) begin
                p1 = 1'b1; w1 = 1'($urandom_range(0, 1));
                a1 = AW'($urandom_range(0, 3)); d1 = DW'($urandom_range(0, 15));
            end
            clr = ($urandom_range(0, 63) == 0);
            do_cycle(clr, {p1, p0}, {w1, w0}, a0, a1, d0, d1, er);
            if (er[0]) p0 = 1'b0;
            if (er[1]) p1 = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
